// File: rtl/uart_tx_fifo_if.sv
// Host-side write port of the UART transmitter: valid/ready push of one data word.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO, programmable baud divisor and runtime
// frame format (5..DATA_W data bits, optional parity, 1 or 2 stop bits).
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 wr,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [3:0]                    cfg_nbits,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_odd,
  input  logic                          cfg_stop2,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] NBITS_MIN = 4'd5;
  localparam logic [3:0] NBITS_MAX = 4'(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic [3:0] eff_nbits(input logic [3:0] n);
    logic [3:0] r;
    if (n < NBITS_MIN) begin
      r = NBITS_MIN;
    end else if (n > NBITS_MAX) begin
      r = NBITS_MAX;
    end else begin
      r = n;
    end
    return r;
  endfunction

  function automatic logic parity_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [CW-1:0]     count_r;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [DIV_W-1:0]  timer_r;
  logic [DIV_W-1:0]  div_r;
  logic [DATA_W-1:0] shreg_r;
  logic [3:0]        bitcnt_r;
  logic [3:0]        nbits_r;
  logic              par_en_r;
  logic              par_odd_r;
  logic              stop2_r;
  logic              stop_cnt_r;
  logic              par_r;
  logic              txd_r;
  logic              tx_done_r;

  logic              fifo_empty_s;
  logic              wr_en_s;
  logic              pop_s;
  logic              done_s;
  logic              bit_end_s;
  logic              last_data_s;
  logic              last_stop_s;

  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign wr.wr_ready  = (count_r != CW'(FIFO_DEPTH));
  assign wr_en_s      = wr.wr_valid && wr.wr_ready;
  assign bit_end_s    = (timer_r == {DIV_W{1'b0}});
  assign last_data_s  = (bitcnt_r == (nbits_r - 4'd1));
  assign last_stop_s  = (stop_cnt_r == stop2_r);

  assign txd        = txd_r;
  assign tx_done    = tx_done_r;
  assign busy       = (state_r != S_IDLE);
  assign fifo_count = count_r;

  // Next-state, FIFO pop and end-of-frame decode.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = S_START;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s && last_data_s) begin
          state_nxt_s = par_en_r ? S_PARITY : S_STOP;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = S_STOP;
        end else begin
          state_nxt_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s && last_stop_s) begin
          done_s = 1'b1;
          // Back-to-back: the next start bit follows the stop bit directly.
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = S_START;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_r] <= wr.wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      count_r <= count_r + CW'(wr_en_s) - CW'(pop_s);
    end
  end

  // Frame sequencer, bit timer, shifter and registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      timer_r    <= {DIV_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      shreg_r    <= {DATA_W{1'b0}};
      bitcnt_r   <= 4'd0;
      nbits_r    <= NBITS_MIN;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      stop2_r    <= 1'b0;
      stop_cnt_r <= 1'b0;
      par_r      <= 1'b0;
      txd_r      <= 1'b1;
      tx_done_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        // Format is frozen here so host config writes only affect later frames.
        shreg_r    <= mem_r[rptr_r];
        div_r      <= baud_div;
        timer_r    <= baud_div;
        nbits_r    <= eff_nbits(cfg_nbits);
        par_en_r   <= cfg_par_en;
        par_odd_r  <= cfg_par_odd;
        stop2_r    <= cfg_stop2;
        stop_cnt_r <= 1'b0;
        bitcnt_r   <= 4'd0;
        par_r      <= 1'b0;
      end else if (state_r != S_IDLE) begin
        timer_r <= bit_end_s ? div_r : (timer_r - DIV_W'(1));
        if (bit_end_s && (state_r == S_DATA)) begin
          shreg_r  <= shreg_r >> 1;
          par_r    <= par_r ^ shreg_r[0];
          bitcnt_r <= bitcnt_r + 4'd1;
        end
        if (bit_end_s && (state_r == S_STOP)) begin
          stop_cnt_r <= 1'b1;
        end
      end
      state_r   <= state_nxt_s;
      tx_done_r <= done_s;
      case (state_r)
        S_START:  txd_r <= 1'b0;
        S_DATA:   txd_r <= shreg_r[0];
        S_PARITY: txd_r <= parity_bit(par_r, par_odd_r);
        S_STOP:   txd_r <= 1'b1;
        default:  txd_r <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: a cycle-level line model (FIFO queue plus queue of expected txd cells).
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DIVW-1:0] baud_div;
  logic [3:0]      cfg_nbits;
  logic            cfg_par_en;
  logic            cfg_par_odd;
  logic            cfg_stop2;
  logic            txd;
  logic            busy;
  logic            tx_done;
  logic [2:0]      fifo_count;

  uart_tx_fifo_if #(.DATA_W(DW)) wif ();

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .clk(clk), .rst(rst), .wr(wif), .baud_div(baud_div), .cfg_nbits(cfg_nbits),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .txd(txd), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic last;
  } cell_t;

  cell_t           lineq[$];
  logic [DW-1:0]   mfifo[$];
  int              checks   = 0;
  int              failures = 0;
  logic            exp_txd  = 1'b1;
  logic            exp_done = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_n(input logic [3:0] n);
    if (n < 4'd5) return 5;
    if (int'(n) > DW) return DW;
    return int'(n);
  endfunction

  // Expand one word into the txd cells it produces under the current config.
  task automatic build_frame(input logic [DW-1:0] w);
    logic bits[$];
    logic p;
    cell_t c;
    int b;
    int n;
    b = int'(baud_div) + 1;
    n = eff_n(cfg_nbits);
    p = cfg_par_odd;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(w[i]);
      p = p ^ w[i];
    end
    if (cfg_par_en) bits.push_back(p);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      for (int k = 0; k < b; k++) begin
        c.v    = bits[j];
        c.last = (j == bits.size() - 1) && (k == b - 1);
        lineq.push_back(c);
      end
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare all outputs.
  task automatic tick();
    logic          acc;
    logic          pend;
    logic [DW-1:0] d;
    cell_t         c;
    acc = wif.wr_valid && (mfifo.size() < DEPTH);
    d   = wif.wr_data;
    @(posedge clk);
    if (rst) begin
      lineq.delete();
      mfifo.delete();
      exp_txd  = 1'b1;
      exp_done = 1'b0;
    end else begin
      pend = (mfifo.size() > 0) && (lineq.size() <= 1);
      if (lineq.size() > 0) begin
        c = lineq.pop_front();
        exp_txd  = c.v;
        exp_done = c.last;
      end else begin
        exp_txd  = 1'b1;
        exp_done = 1'b0;
      end
      if (pend) build_frame(mfifo.pop_front());
      if (acc) mfifo.push_back(d);
    end
    #1;
    check("txd", 16'(txd), 16'(exp_txd));
    check("tx_done", 16'(tx_done), 16'(exp_done));
    check("busy", 16'(busy), 16'(lineq.size() > 0));
    check("fifo_count", 16'(fifo_count), 16'(mfifo.size()));
    check("wr_ready", 16'(wif.wr_ready), 16'(mfifo.size() < DEPTH));
  endtask

  task automatic write1(input logic [DW-1:0] d);
    wif.wr_valid = 1'b1;
    wif.wr_data  = d;
    tick();
    wif.wr_valid = 1'b0;
  endtask

  task automatic run_until_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (tx_done === 1'b1) break;
    end
    check("done_seen", 16'(tx_done), 16'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((lineq.size() > 0 || mfifo.size() > 0 || busy !== 1'b0) && k < 3000) begin
      tick();
      k++;
    end
    check("drained", 16'(busy), 16'd0);
  endtask

  task automatic set_cfg(input int bd, input int nb, input logic pe, input logic po, input logic s2);
    baud_div    = DIVW'(bd);
    cfg_nbits   = 4'(nb);
    cfg_par_en  = pe;
    cfg_par_odd = po;
    cfg_stop2   = s2;
  endtask

  initial begin
    int n;
    int stall;
    int guard;
    rst          = 1'b1;
    wif.wr_valid = 1'b0;
    wif.wr_data  = '0;
    set_cfg(3, 8, 1'b0, 1'b0, 1'b0);

    repeat (3) tick();
    check("rst_txd", 16'(txd), 16'd1);
    check("rst_fifo_count", 16'(fifo_count), 16'd0);
    rst = 1'b0;
    tick();

    // 8N1, 4 cycles per bit: done pulse 41 edges after the accepting edge.
    write1(8'hA5);
    run_until_done(200, n);
    check("a5_done_latency", 16'(n), 16'd41);
    drain();

    // 7E2 then 7O2, one cycle per bit.
    set_cfg(0, 7, 1'b1, 1'b0, 1'b1);
    write1(8'h41);
    run_until_done(100, n);
    check("7e2_done_latency", 16'(n), 16'd12);
    drain();
    cfg_par_odd = 1'b1;
    write1(8'h41);
    run_until_done(100, n);
    check("7o2_done_latency", 16'(n), 16'd12);
    drain();

    // Six writes held valid; the sixth must wait for a pop.
    set_cfg(1, 8, 1'b0, 1'b0, 1'b0);
    stall = 0;
    for (int w = 0; w < 6; w++) begin
      wif.wr_valid = 1'b1;
      wif.wr_data  = DW'($urandom);
      guard = 0;
      while (mfifo.size() >= DEPTH && guard < 200) begin
        tick();
        guard++;
        if (w == 5) stall++;
      end
      tick();
    end
    wif.wr_valid = 1'b0;
    check("sixth_write_stalled", 16'(stall > 0), 16'd1);
    drain();

    // Write lands on the same edge as the end-of-frame pop with two queued.
    write1(8'h11);
    write1(8'h22);
    write1(8'h33);
    guard = 0;
    while (!(mfifo.size() > 0 && lineq.size() <= 1) && guard < 200) begin
      tick();
      guard++;
    end
    check("pre_pop_count", 16'(fifo_count), 16'd2);
    write1(8'h44);
    check("wr_pop_count", 16'(fifo_count), 16'd2);
    drain();

    // Config switched mid-frame: current frame stays 8N1, next one is 5O2.
    write1(8'h3C);
    write1(8'h5A);
    repeat (5) tick();
    set_cfg(1, 5, 1'b1, 1'b1, 1'b1);
    run_until_done(200, n);
    run_until_done(200, n);
    check("5o2_frame_len", 16'(n), 16'd18);
    drain();

    // Reset in the middle of the data bits.
    set_cfg(3, 8, 1'b0, 1'b0, 1'b0);
    write1(8'h00);
    write1(8'hFF);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_txd", 16'(txd), 16'd1);
    check("midrst_count", 16'(fifo_count), 16'd0);
    repeat (60) tick();

    // Random traffic and format changes, including out-of-range nbits.
    for (int i = 0; i < 1500; i++) begin
      wif.wr_valid = ($urandom_range(0, 2) == 0);
      wif.wr_data  = DW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        set_cfg($urandom_range(0, 2), $urandom_range(0, 15), 1'($urandom),
                1'($urandom), 1'($urandom));
      end
      tick();
    end
    wif.wr_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO, programmable baud divider and runtime frame format: 5..DATA_W data bits, optional even/odd parity, and 1 or 2 stop bits. The host pushes words through a valid/ready write port. The block serialises them LSB-first on txd, with back-to-back frames and no idle gap while the FIFO holds data. It sits between the bus-side register file and the pad, and replaces the fixed 8N1 transmitter.

Parameters:
DATA_W, 8, maximum data bits per frame (5..9)
FIFO_DEPTH, 4, transmit FIFO entries (power of 2, >=2)
DIV_W, 16, width of baud divisor

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
wr_data  input  DATA_W  word to transmit
wr_valid  input  1  host write request
wr_ready  output  1  FIFO not full; a write is accepted on a clk edge with wr_valid&wr_ready
baud_div  input  DIV_W  bit period = baud_div+1 clk cycles; 0 means 1 cycle per bit
cfg_nbits  input  4  data bits per frame; <5 treated as 5, >DATA_W treated as DATA_W
cfg_par_en  input  1  append parity bit
cfg_par_odd  input  1  1=odd parity, 0=even
cfg_stop2  input  1  1=two stop bits
txd  output  1  serial output, idle high
busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse at end of last stop bit
fifo_count  output  log2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (rst high at clk edge): txd=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1, FSM=IDLE, all counters cleared. Reset mid-frame aborts the frame; txd returns to 1 on the next edge and FIFO contents are discarded.
- FIFO: circular buffer with read/write pointers and a count. Write when full is ignored (wr_ready=0). Simultaneous write and pop when full: write is still refused; there is no bypass. Simultaneous write and pop otherwise: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO is non-empty, pop the head into the shift register, latch baud_div, cfg_* and effective nbits, clear parity accumulator, then go to START. Config changes mid-frame have no effect.
- Bit timer: loaded with latched baud_div on entry to each bit. The state advances when the timer reaches 0 while the bit is held. Every bit lasts exactly baud_div+1 cycles.
- START: txd=0 for one bit, then go to DATA.
- DATA: txd = shift register bit 0. At end of each bit, shift right and XOR the sent bit into the parity accumulator. After nbits bits go to PARITY if cfg_par_en, else go to STOP.
- PARITY: txd = accumulator XOR cfg_par_odd, then go to STOP.
- STOP: txd=1 for 1 or 2 bit periods. At the end, pulse tx_done for one cycle. If the FIFO is non-empty in that same cycle, pop it and go directly to START with no idle bit; else go to IDLE.
- Data bits above nbits in wr_data are ignored.
- Latency: a write accepted at edge N into an empty FIFO while IDLE makes txd fall at edge N+2.
- txd is driven from a register; it is glitch-free.

Test Plan:
- Reset/idle: hold rst 3 cycles -> txd=1, busy=0, wr_ready=1, fifo_count=0.
- 8N1, baud_div=3, write 0xA5 -> txd low at N+2; then bits 1,0,1,0,0,1,0,1 each 4 cycles; stop 4 cycles; tx_done pulse; total frame 40 cycles.
- 7E2, baud_div=0, write 0x41 -> start, data 1,0,0,0,0,0,1, parity 0, two stop bits, 11 cycles. Repeat with cfg_par_odd=1 -> parity bit 1.
- FIFO full/back-to-back: write 5 words with DEPTH=4 while the first frame is active -> the 6th write stalls (wr_ready=0) until a pop. All frames are contiguous with no idle bits between stop and start.
- Simultaneous write and pop at count=2 -> count stays 2. Config change mid-frame (8N1 -> 5O2) -> the current frame stays 8N1 and the next frame uses 5O2.
- Reset mid-DATA -> txd=1 next cycle, fifo_count=0, no tx_done pulse.
